pipelined_muldiv_alu: RTL and testbench
=======================================

# pipelined_muldiv_alu

Parametrised, registered ALU for the execute stage that adds an iterative multiply/divide unit with HI/LO registers to the standard add/sub/logic/shift/compare/LUI operations. Single-cycle ops return one cycle after acceptance. MUL/DIV run for WIDTH cycles behind a valid/ready handshake while the pipeline stalls on `in_ready`. The block sits between the ID/EX register and the EX/MEM register and produces result, overflow, zero and divide-by-zero flags.

## Interface
- WIDTH, 32, operand/result width; even, ≥8
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operation presented
- in_ready  out  1  block can accept an operation this cycle
- op  in  4  operation code (see Operation)
- sgn  in  1  1 = signed semantics for SLT/MUL/DIV/overflow
- a  in  WIDTH  operand A (shift amount in a[SHW-1:0])
- b  in  WIDTH  operand B (value shifted/loaded for shifts and LUI)
- out_valid  out  1  one-cycle pulse, result fields valid
- result  out  WIDTH  operation result
- over  out  1  signed overflow (ADD/SUB with sgn=1 only)
- zero  out  1  result == 0
- dz  out  1  divide by zero occurred (DIV only)

## Operation
- Op codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 LUI (b << WIDTH/2), 7 SLT (result 1/0, signedness from sgn), 8 SLL, 9 SRL, 10 SRA (b shifted by a[SHW-1:0]), 11 MUL, 12 DIV, 13 MFHI, 14 MFLO, 15 reserved → result 0, no flags.
- ADD/SUB wrap modulo 2^WIDTH. over = sgn & operand signs (a, effective b) equal & result sign differs. Otherwise over=0.
- MUL: {HI,LO} = a*b, full 2·WIDTH-bit product, signed if sgn. result = LO.
- DIV: LO = quotient, HI = remainder. Signed: quotient truncates toward zero, remainder takes dividend sign. MIN/−1: LO=MIN, HI=0, dz=0. b=0: LO = all ones, HI = a, dz=1. result = LO.
- MFHI/MFLO: result = HI/LO; these ops are single-cycle.
- HI/LO change only on MUL/DIV completion.
- FSM: IDLE → (accept MUL) MUL → IDLE; IDLE → (accept DIV) DIV → IDLE. Single-cycle ops stay in IDLE.
- in_ready = (state == IDLE). Operations presented while in_ready=0 are ignored; the upstream stage holds them.

## Timing
- Accept = in_valid & in_ready at a rising edge t.
- Single-cycle ops: out_valid and fields at t+1. Back-to-back acceptance allowed every cycle.
- MUL/DIV: WIDTH iteration cycles (one bit per cycle; sign correction is folded into the final edge). HI/LO are written and state returns to IDLE at edge t+WIDTH. out_valid is asserted in the cycle after that edge.
- in_ready rises in the same cycle out_valid pulses. An MFHI/MFLO accepted then reads the new HI/LO.
- No output backpressure: out_valid is a single-cycle pulse.
- Reset values: state IDLE, HI=LO=0, out_valid=0, result=0, over=zero=dz=0, in_ready=1 after reset release.
- Reset asserted mid-MUL/DIV aborts the operation. No out_valid is produced and HI/LO read 0.
- over, zero and dz are held at 0 in any cycle where out_valid=0.

## Structure
- Package `alu_pkg`: op-code localparams (OP_ADD…OP_MFLO) and FSM state encoding (ST_IDLE, ST_MUL, ST_DIV).
- Sub-module `muldiv_core`: iterative shift-add multiplier / restoring divider.
  - Ports: start, sgn, a, b, done, hi, lo, dz.
  - Operates on magnitudes internally.
  - Top-level owns the handshake, single-cycle datapath and the HI/LO registers.

## Test plan
- WIDTH=32. ADD sgn=1 a=0x7FFFFFFF, b=1 → at t+1 result=0x80000000, over=1, zero=0. The same operation with sgn=0 → over=0.
- SUB a=5, b=5, then SRA a=4, b=0x80000000 on consecutive cycles.
  - Expect result=0, zero=1 at t+1.
  - Expect result=0xF8000000 at t+2.
- MUL sgn=1 a=−3, b=7:
  - in_ready low for 32 cycles.
  - out_valid at t+33 with result=0xFFFFFFEB.
  - Following MFHI → 0xFFFFFFFF.
- DIV sgn=1 a=−7, b=2 → LO=−3, HI=−1. Then DIV a=9, b=0 → result=0xFFFFFFFF, dz=1, MFHI → 9.
- MIN/−1 signed DIV → LO=0x80000000, HI=0, dz=0.
- Assert rst_n low at iteration 10 of a MUL → no out_valid, in_ready=1 after release, MFLO → 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared op codes and FSM state encoding for the execute-stage ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOR  = 4'd5;
  localparam logic [3:0] OP_LUI  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;
  localparam logic [3:0] OP_DIV  = 4'd12;
  localparam logic [3:0] OP_MFHI = 4'd13;
  localparam logic [3:0] OP_MFLO = 4'd14;
  localparam logic [3:0] OP_RSV  = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_core.sv
// Iterative magnitude shift-add multiplier / restoring divider, one bit per cycle.
// The last iteration and the sign fix-up are presented combinationally alongside done.
module muldiv_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dz
);

  localparam int CW = $clog2(WIDTH);

  logic             r_busy;
  logic [CW-1:0]    r_cnt;
  logic             r_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dz;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_mc;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH-1:0]   w_mc_add;
  logic [WIDTH:0]     w_msum;
  logic [WIDTH:0]     w_dsh;
  logic [WIDTH:0]     w_ddiff;
  logic [WIDTH-1:0]   w_nhi;
  logic [WIDTH-1:0]   w_nlo;
  logic [2*WIDTH-1:0] w_prod;

  assign w_a_mag = (sgn && a[WIDTH-1]) ? -a : a;
  assign w_b_mag = (sgn && b[WIDTH-1]) ? -b : b;

  // Multiply: {hi,lo} shifts right, multiplier in lo. Divide: remainder in hi, quotient shifts into lo.
  always_comb begin
    w_mc_add = r_lo[0] ? r_mc : '0;
    w_msum   = {1'b0, r_hi} + {1'b0, w_mc_add};
    w_dsh    = {r_hi, r_lo[WIDTH-1]};
    w_ddiff  = w_dsh - {1'b0, r_mc};
    if (r_div) begin
      w_nhi = w_ddiff[WIDTH] ? w_dsh[WIDTH-1:0] : w_ddiff[WIDTH-1:0];
      w_nlo = {r_lo[WIDTH-2:0], ~w_ddiff[WIDTH]};
    end else begin
      w_nhi = w_msum[WIDTH:1];
      w_nlo = {w_msum[0], r_lo[WIDTH-1:1]};
    end
    w_prod = r_neg_q ? -{w_nhi, w_nlo} : {w_nhi, w_nlo};
    hi     = w_prod[2*WIDTH-1:WIDTH];
    lo     = w_prod[WIDTH-1:0];
    if (r_div) begin
      if (r_dz) begin
        hi = r_a;
        lo = '1;
      end else begin
        hi = r_neg_r ? -w_nhi : w_nhi;
        lo = r_neg_q ? -w_nlo : w_nlo;
      end
    end
  end

  assign done = r_busy && (r_cnt == '0);
  assign dz   = r_div && r_dz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
      r_a     <= '0;
      r_mc    <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else if (start) begin
      r_busy  <= 1'b1;
      r_cnt   <= CW'(WIDTH - 1);
      r_div   <= is_div;
      r_neg_q <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
      r_neg_r <= sgn & a[WIDTH-1];
      r_dz    <= is_div & (b == '0);
      r_a     <= a;
      r_mc    <= w_b_mag;
      r_hi    <= '0;
      r_lo    <= w_a_mag;
    end else if (r_busy) begin
      r_hi  <= w_nhi;
      r_lo  <= w_nlo;
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == '0) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pipelined_muldiv_alu.sv
// Execute-stage ALU: registered single-cycle ops plus an iterative MUL/DIV owning HI/LO.
// state   | meaning
// ST_IDLE | accepting ops, single-cycle results issue from here
// ST_MUL  | multiply iterating, upstream stalled
// ST_DIV  | divide iterating, upstream stalled
module pipelined_muldiv_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             over,
  output logic             zero,
  output logic             dz
);

  state_t           r_state;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_over;
  logic             r_zero;
  logic             r_dz;

  logic             w_acc;
  logic             w_md_start;
  logic             w_md_done;
  logic [WIDTH-1:0] w_md_hi;
  logic [WIDTH-1:0] w_md_lo;
  logic             w_md_dz;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_alu;
  logic             w_over;
  logic             w_lt;
  logic [SHW-1:0]   w_sh;

  assign in_ready   = (r_state == ST_IDLE);
  assign w_acc      = in_valid && in_ready;
  assign w_md_start = w_acc && ((op == OP_MUL) || (op == OP_DIV));
  assign w_sh       = a[SHW-1:0];
  assign w_lt       = sgn ? ($signed(a) < $signed(b)) : (a < b);

  always_comb begin
    w_sum  = a + b;
    w_diff = a - b;
    w_alu  = '0;
    w_over = 1'b0;
    case (op)
      OP_ADD: begin
        w_alu  = w_sum;
        w_over = sgn && (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_alu  = w_diff;
        w_over = sgn && (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  w_alu = a & b;
      OP_OR:   w_alu = a | b;
      OP_XOR:  w_alu = a ^ b;
      OP_NOR:  w_alu = ~(a | b);
      OP_LUI:  w_alu = b << (WIDTH / 2);
      OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, w_lt};
      OP_SLL:  w_alu = b << w_sh;
      OP_SRL:  w_alu = b >> w_sh;
      OP_SRA:  w_alu = $signed(b) >>> w_sh;
      OP_MFHI: w_alu = r_hi;
      OP_MFLO: w_alu = r_lo;
      default: w_alu = '0;
    endcase
  end

  muldiv_core #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (w_md_start),
    .is_div (op == OP_DIV),
    .sgn    (sgn),
    .a      (a),
    .b      (b),
    .done   (w_md_done),
    .hi     (w_md_hi),
    .lo     (w_md_lo),
    .dz     (w_md_dz)
  );

  // Flags clear by default so they only ever accompany an out_valid pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_hi        <= '0;
      r_lo        <= '0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_over      <= 1'b0;
      r_zero      <= 1'b0;
      r_dz        <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_over      <= 1'b0;
      r_zero      <= 1'b0;
      r_dz        <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_acc) begin
            if (op == OP_MUL) begin
              r_state <= ST_MUL;
            end else if (op == OP_DIV) begin
              r_state <= ST_DIV;
            end else begin
              r_out_valid <= 1'b1;
              r_result    <= w_alu;
              r_over      <= w_over;
              r_zero      <= (op != OP_RSV) && (w_alu == '0);
            end
          end
        end
        ST_MUL, ST_DIV: begin
          if (w_md_done) begin
            r_state     <= ST_IDLE;
            r_hi        <= w_md_hi;
            r_lo        <= w_md_lo;
            r_out_valid <= 1'b1;
            r_result    <= w_md_lo;
            r_zero      <= (w_md_lo == '0);
            r_dz        <= w_md_dz;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign over      = r_over;
  assign zero      = r_zero;
  assign dz        = r_dz;

endmodule

// File: tb/tb_pipelined_muldiv_alu.sv
// Directed-vector bench for pipelined_muldiv_alu at WIDTH=32.
module tb_pipelined_muldiv_alu;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   op = 4'd0;
  logic         sgn = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic [W-1:0] result;
  logic         over;
  logic         zero;
  logic         dz;

  int n_chk = 0;
  int n_err = 0;
  int edges;
  int low;
  int pulses;

  pipelined_muldiv_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .sgn       (sgn),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .result    (result),
    .over      (over),
    .zero      (zero),
    .dz        (dz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] o, input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    in_valid = 1'b1;
    op       = o;
    sgn      = s;
    a        = x;
    b        = y;
  endtask

  task automatic issue(input logic [3:0] o, input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    drive(o, s, x, y);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n_edges, output int n_low);
    n_edges = 0;
    n_low   = 0;
    while (!out_valid && n_edges < 100) begin
      if (!in_ready) n_low++;
      step();
      n_edges++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12 rst_n = 1'b1;
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_flags", {over, zero, dz}, 0);

    issue(OP_ADD, 1'b1, 32'h7FFF_FFFF, 32'h1);
    chk("add_s_valid", out_valid, 1);
    chk("add_s_result", result, 32'h8000_0000);
    chk("add_s_over", over, 1);
    chk("add_s_zero", zero, 0);
    issue(OP_ADD, 1'b0, 32'h7FFF_FFFF, 32'h1);
    chk("add_u_over", over, 0);
    issue(OP_SUB, 1'b1, 32'h8000_0000, 32'h1);
    chk("sub_s_result", result, 32'h7FFF_FFFF);
    chk("sub_s_over", over, 1);

    drive(OP_SUB, 1'b0, 32'd5, 32'd5);
    step();
    drive(OP_SRA, 1'b0, 32'd4, 32'h8000_0000);
    chk("sub_valid", out_valid, 1);
    chk("sub_result", result, 0);
    chk("sub_zero", zero, 1);
    step();
    in_valid = 1'b0;
    chk("sra_valid", out_valid, 1);
    chk("sra_result", result, 32'hF800_0000);
    chk("sra_zero", zero, 0);
    step();
    chk("idle_no_valid", out_valid, 0);

    issue(OP_SLT, 1'b1, 32'hFFFF_FFFF, 32'h1);
    chk("slt_s", result, 1);
    issue(OP_SLT, 1'b0, 32'hFFFF_FFFF, 32'h1);
    chk("slt_u", result, 0);
    chk("slt_u_zero", zero, 1);
    issue(OP_LUI, 1'b0, 32'h0, 32'h0000_1234);
    chk("lui", result, 32'h1234_0000);
    issue(OP_RSV, 1'b0, 32'h0, 32'h0);
    chk("rsv_valid", out_valid, 1);
    chk("rsv_result_flags", {result[3:0], zero, over, dz}, 0);

    issue(OP_MUL, 1'b1, 32'hFFFF_FFFD, 32'd7);
    wait_out(edges, low);
    chk("mul_latency", W'(edges), 32);
    chk("mul_ready_low", W'(low), 32);
    chk("mul_valid", out_valid, 1);
    chk("mul_ready_back", in_ready, 1);
    chk("mul_lo", result, 32'hFFFF_FFEB);
    issue(OP_MFHI, 1'b0, 32'h0, 32'h0);
    chk("mul_mfhi", result, 32'hFFFF_FFFF);
    issue(OP_MFLO, 1'b0, 32'h0, 32'h0);
    chk("mul_mflo", result, 32'hFFFF_FFEB);

    issue(OP_MUL, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_out(edges, low);
    chk("mulu_lo", result, 32'h1);
    issue(OP_MFHI, 1'b0, 32'h0, 32'h0);
    chk("mulu_hi", result, 32'hFFFF_FFFE);

    issue(OP_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_out(edges, low);
    chk("div_latency", W'(edges), 32);
    chk("div_lo", result, 32'hFFFF_FFFD);
    chk("div_dz", dz, 0);
    issue(OP_MFHI, 1'b0, 32'h0, 32'h0);
    chk("div_hi", result, 32'hFFFF_FFFF);

    issue(OP_DIV, 1'b1, 32'd9, 32'd0);
    wait_out(edges, low);
    chk("dz_lo", result, 32'hFFFF_FFFF);
    chk("dz_flag", dz, 1);
    issue(OP_MFHI, 1'b0, 32'h0, 32'h0);
    chk("dz_hi", result, 32'd9);
    chk("dz_cleared", dz, 0);

    issue(OP_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_out(edges, low);
    chk("minneg_lo", result, 32'h8000_0000);
    chk("minneg_dz", dz, 0);
    issue(OP_MFHI, 1'b0, 32'h0, 32'h0);
    chk("minneg_hi", result, 32'h0);

    issue(OP_DIV, 1'b0, 32'd100, 32'd7);
    wait_out(edges, low);
    chk("divu_lo", result, 32'd14);
    issue(OP_MFHI, 1'b0, 32'h0, 32'h0);
    chk("divu_hi", result, 32'd2);

    issue(OP_MUL, 1'b0, 32'd3, 32'd5);
    repeat (10) step();
    chk("abort_busy", in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("abort_rst_valid", out_valid, 0);
    chk("abort_rst_ready", in_ready, 1);
    step();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) pulses++;
      step();
    end
    chk("abort_no_valid", W'(pulses), 0);
    chk("abort_ready", in_ready, 1);
    issue(OP_MFLO, 1'b0, 32'h0, 32'h0);
    chk("abort_mflo", result, 0);
    issue(OP_MFHI, 1'b0, 32'h0, 32'h0);
    chk("abort_mfhi", result, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
